// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcodes, instruction field positions and the ID/EX bundle.
package dlx_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_FTYPE = 6'h01,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQZ  = 6'h04,
        OP_BNEZ  = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LHI   = 6'h0F,
        OP_JR    = 6'h12,
        OP_JALR  = 6'h13,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RS1_MSB  = 25;
    localparam int RS1_LSB  = 21;
    localparam int RS2_MSB  = 20;
    localparam int RS2_LSB  = 16;
    localparam int RDR_MSB  = 15;
    localparam int RDR_LSB  = 11;
    localparam int FUNC_MSB = 10;
    localparam int IMM_MSB  = 15;
    localparam int OFF_MSB  = 25;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [10:0] func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        is_load;
    } id_ex_t;

    function automatic logic is_rtype(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_FTYPE: is_rtype = 1'b1;
            default:            is_rtype = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_op = 1'b1;
            default:                             is_load_op = 1'b0;
        endcase
    endfunction

    // Stores read their data register through the rs2 slot.
    function automatic logic uses_rs2(input logic [5:0] op);
        uses_rs2 = is_rtype(op) || is_store(op);
    endfunction

endpackage

// File: rtl/decode_hazard.sv
// Load-use and writeback-conflict comparators for the decode stage.
// WB_BYPASS_EN: forward matching writeback data instead of stalling on it.
module decode_hazard
    import dlx_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       rs2_used,
    input  logic       wb_en,
    input  logic [4:0] wb_rd,
    output logic       fwd_a,
    output logic       fwd_b,
    output logic       stall
);

    logic load_use_s;
    logic wb_hit_a_s;
    logic wb_hit_b_s;

    // Source-vs-destination comparators for the load in EX and the writeback port.
    always_comb begin
        load_use_s = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == rs1) || (rs2_used && (ex_rd == rs2)));
        wb_hit_a_s = wb_en && (wb_rd != 5'd0) && (wb_rd == rs1);
        wb_hit_b_s = wb_en && (wb_rd != 5'd0) && rs2_used && (wb_rd == rs2);
    end

`ifdef WB_BYPASS_EN
    // Writeback matches are forwarded; only the load-use case stalls.
    always_comb begin
        fwd_a = wb_hit_a_s;
        fwd_b = wb_hit_b_s;
        stall = load_use_s;
    end
`else
    // Without forwarding, wait one cycle for the register file to commit.
    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        stall = load_use_s || wb_hit_a_s || wb_hit_b_s;
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// DLX instruction decode with ID/EX pipeline register and valid/ready handshakes.
// WB_BYPASS_EN (optional): forward writeback data to operands instead of stalling.
module decode_stage
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    input  logic [31:0] S1,
    input  logic [31:0] S2,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [5:0]  ex_op,
    output logic [10:0] ex_func,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_we,
    output logic        ex_is_load
);

    id_ex_t      id_ex_r;
    id_ex_t      next_s;
    logic [5:0]  op_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic        rs2_used_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_s;
    logic        fwd_a_s;
    logic        fwd_b_s;
    logic        stall_s;
    logic        hold_s;
    logic        id_ready_s;

    // Field extraction and register-file read addresses.
    always_comb begin
        op_s       = if_instr[OP_MSB:OP_LSB];
        rs1_s      = if_instr[RS1_MSB:RS1_LSB];
        rs2_used_s = uses_rs2(op_s);
        rs2_s      = rs2_used_s ? if_instr[RS2_MSB:RS2_LSB] : 5'd0;
    end

    // Destination register selection by instruction class.
    always_comb begin
        if (is_rtype(op_s)) begin
            rd_s = if_instr[RDR_MSB:RDR_LSB];
        end else begin
            case (op_s)
                OP_JAL, OP_JALR:                               rd_s = LINK_REG;
                OP_SB, OP_SH, OP_SW, OP_BEQZ, OP_BNEZ, OP_J, OP_JR: rd_s = 5'd0;
                default:                                       rd_s = if_instr[RS2_MSB:RS2_LSB];
            endcase
        end
    end

    // Immediate extension: logical ops zero-extend, LHI shifts up, jumps use off26.
    always_comb begin
        case (op_s)
            OP_ANDI, OP_ORI, OP_XORI: imm_s = {16'd0, if_instr[IMM_MSB:0]};
            OP_LHI:                   imm_s = {if_instr[IMM_MSB:0], 16'd0};
            OP_J, OP_JAL:             imm_s = {{6{if_instr[OFF_MSB]}}, if_instr[OFF_MSB:0]};
            default:                  imm_s = {{16{if_instr[IMM_MSB]}}, if_instr[IMM_MSB:0]};
        endcase
    end

    decode_hazard u_hazard (
        .ex_valid   (id_ex_r.valid),
        .ex_is_load (id_ex_r.is_load),
        .ex_rd      (id_ex_r.rd),
        .rs1        (rs1_s),
        .rs2        (rs2_s),
        .rs2_used   (rs2_used_s),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .fwd_a      (fwd_a_s),
        .fwd_b      (fwd_b_s),
        .stall      (stall_s)
    );

    // Next ID/EX contents; r0 reads as zero regardless of the register file.
    always_comb begin
        next_s.valid   = 1'b1;
        next_s.op      = op_s;
        next_s.func    = is_rtype(op_s) ? if_instr[FUNC_MSB:0] : 11'd0;
        next_s.imm     = imm_s;
        next_s.pc      = if_pc;
        next_s.rd      = rd_s;
        next_s.we      = (rd_s != 5'd0);
        next_s.is_load = is_load_op(op_s);
        if (rs1_s == 5'd0) begin
            next_s.a = 32'd0;
        end else if (fwd_a_s) begin
            next_s.a = wb_data;
        end else begin
            next_s.a = S1;
        end
        if (rs2_s == 5'd0) begin
            next_s.b = 32'd0;
        end else if (fwd_b_s) begin
            next_s.b = wb_data;
        end else begin
            next_s.b = S2;
        end
    end

    // Handshake: flush always consumes, a blocked EX or a hazard refuses.
    always_comb begin
        hold_s = id_ex_r.valid && !ex_ready;
        if (rst) begin
            id_ready_s = 1'b0;
        end else if (flush) begin
            id_ready_s = 1'b1;
        end else if (hold_s) begin
            id_ready_s = 1'b0;
        end else if (stall_s) begin
            id_ready_s = 1'b0;
        end else begin
            id_ready_s = 1'b1;
        end
    end

    // ID/EX register: load on accept, bubble when advancing empty, hold when blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_r <= '0;
        end else if (flush) begin
            id_ex_r.valid <= 1'b0;
        end else if (!hold_s) begin
            if (if_valid && id_ready_s) begin
                id_ex_r <= next_s;
            end else begin
                id_ex_r.valid <= 1'b0;
            end
        end else begin
            id_ex_r <= id_ex_r;
        end
    end

    assign id_ready   = id_ready_s;
    assign Rs1        = rs1_s;
    assign Rs2        = rs2_s;
    assign ex_valid   = id_ex_r.valid;
    assign ex_op      = id_ex_r.op;
    assign ex_func    = id_ex_r.func;
    assign ex_a       = id_ex_r.a;
    assign ex_b       = id_ex_r.b;
    assign ex_imm     = id_ex_r.imm;
    assign ex_pc      = id_ex_r.pc;
    assign ex_rd      = id_ex_r.rd;
    assign ex_we      = id_ex_r.we;
    assign ex_is_load = id_ex_r.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow WB_BYPASS_EN if defined.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [31:0] S1;
    logic [31:0] S2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [10:0] ex_func;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        ex_is_load;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [10:0] func;
    } vec_t;

    vec_t vecs[8];

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .S1         (S1),
        .S2         (S2),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_func    (ex_func),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_imm     (ex_imm),
        .ex_pc      (ex_pc),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] s1, input logic [31:0] s2);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        S1       = s1;
        S2       = s2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        S1 = 32'd0; S2 = 32'd0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        flush = 1'b0; ex_ready = 1'b1;
        cycle();
        cycle();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %b expected 0", id_ready); end
        checks++; if ({ex_a, ex_b, ex_imm, ex_pc, ex_rd, ex_we} !== 134'd0) begin errors++; $display("FAIL reset_ex_bundle: a=%h b=%h imm=%h rd=%0d expected all 0", ex_a, ex_b, ex_imm, ex_rd); end
        rst = 1'b0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", id_ready); end
    endtask

    task automatic test_decode_table();
        vecs[0] = '{32'h00221820, 32'd5,      32'd7,      5'd2, 32'd5,     32'd7,      32'h00001820, 5'd2 + 5'd1, 1'b1, 11'h020};
        vecs[1] = '{32'h2007FFFF, 32'h1234,   32'h5678,   5'd0, 32'd0,     32'd0,      32'hFFFFFFFF, 5'd7,  1'b1, 11'h000};
        vecs[2] = '{32'h3407FFFF, 32'h1234,   32'h5678,   5'd0, 32'd0,     32'd0,      32'h0000FFFF, 5'd7,  1'b1, 11'h000};
        vecs[3] = '{32'h3C021234, 32'h1111,   32'h2222,   5'd0, 32'd0,     32'd0,      32'h12340000, 5'd2,  1'b1, 11'h000};
        vecs[4] = '{32'h0BFFFFFC, 32'hAAAA,   32'hBBBB,   5'd0, 32'hAAAA,  32'd0,      32'hFFFFFFFC, 5'd0,  1'b0, 11'h000};
        vecs[5] = '{32'h0C000010, 32'hCCCC,   32'hDDDD,   5'd0, 32'd0,     32'd0,      32'h00000010, 5'd31, 1'b1, 11'h000};
        vecs[6] = '{32'hAC250008, 32'h100,    32'hABCD,   5'd5, 32'h100,   32'hABCD,   32'h00000008, 5'd0,  1'b0, 11'h000};
        vecs[7] = '{32'h10408000, 32'h33,     32'h44,     5'd0, 32'h33,    32'd0,      32'hFFFF8000, 5'd0,  1'b0, 11'h000};
        for (int i = 0; i < 8; i++) begin
            present(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 32'd4, vecs[i].s1, vecs[i].s2);
            checks++; if (Rs2 !== vecs[i].rs2) begin errors++; $display("FAIL dec%0d_rs2: got %0d expected %0d", i, Rs2, vecs[i].rs2); end
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL dec%0d_ready: got %b expected 1", i, id_ready); end
            cycle();
            checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid: got %b expected 1", i, ex_valid); end
            checks++; if (ex_a !== vecs[i].a) begin errors++; $display("FAIL dec%0d_a: got %h expected %h", i, ex_a, vecs[i].a); end
            checks++; if (ex_b !== vecs[i].b) begin errors++; $display("FAIL dec%0d_b: got %h expected %h", i, ex_b, vecs[i].b); end
            checks++; if (ex_imm !== vecs[i].imm) begin errors++; $display("FAIL dec%0d_imm: got %h expected %h", i, ex_imm, vecs[i].imm); end
            checks++; if (ex_rd !== vecs[i].rd || ex_we !== vecs[i].we) begin errors++; $display("FAIL dec%0d_rd_we: got %0d/%b expected %0d/%b", i, ex_rd, ex_we, vecs[i].rd, vecs[i].we); end
            checks++; if (ex_func !== vecs[i].func || ex_op !== vecs[i].instr[31:26]) begin errors++; $display("FAIL dec%0d_op_func: got %h/%h expected %h/%h", i, ex_op, ex_func, vecs[i].instr[31:26], vecs[i].func); end
            checks++; if (ex_pc !== 32'h1000 + 32'(i) * 32'd4 || ex_is_load !== 1'b0) begin errors++; $display("FAIL dec%0d_pc_load: got %h/%b expected %h/0", i, ex_pc, ex_is_load, 32'h1000 + 32'(i) * 32'd4); end
        end
    endtask

    task automatic test_load_use();
        present(1'b1, 32'h8C240000, 32'h2000, 32'h100, 32'd0);
        checks++; if (Rs1 !== 5'd1) begin errors++; $display("FAIL lw_rs1: got %0d expected 1", Rs1); end
        cycle();
        checks++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1 || ex_rd !== 5'd4) begin errors++; $display("FAIL lw_issue: valid=%b load=%b rd=%0d expected 1/1/4", ex_valid, ex_is_load, ex_rd); end
        present(1'b1, 32'h00842820, 32'h2004, 32'd9, 32'd9);
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b expected 0", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", ex_valid); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_retry_ready: got %b expected 1", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_a !== 32'd9 || ex_pc !== 32'h2004) begin errors++; $display("FAIL lu_issue: valid=%b rd=%0d a=%h pc=%h expected 1/5/9/2004", ex_valid, ex_rd, ex_a, ex_pc); end
    endtask

    task automatic test_wb_conflict();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd222222;
        present(1'b1, 32'h00600820, 32'h3000, 32'd9, 32'h77);
`ifdef WB_BYPASS_EN
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL wb_ready: got %b expected 1", id_ready); end
        cycle();
        wb_en = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_a !== 32'd222222 || ex_b !== 32'd0) begin errors++; $display("FAIL wb_bypass: valid=%b a=%0d b=%h expected 1/222222/0", ex_valid, ex_a, ex_b); end
`else
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL wb_ready: got %b expected 0", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL wb_bubble: got %b expected 0", ex_valid); end
        wb_en = 1'b0;
        present(1'b1, 32'h00600820, 32'h3000, 32'd222222, 32'h77);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL wb_retry_ready: got %b expected 1", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b1 || ex_a !== 32'd222222 || ex_b !== 32'd0) begin errors++; $display("FAIL wb_regs: valid=%b a=%0d b=%h expected 1/222222/0", ex_valid, ex_a, ex_b); end
`endif
    endtask

    task automatic test_flush();
        flush = 1'b1;
        present(1'b1, 32'h2007FFFF, 32'h4000, 32'd0, 32'd0);
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", id_ready); end
        cycle();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b expected 0", ex_valid); end
        present(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", ex_valid); end
    endtask

    task automatic test_back_pressure();
        present(1'b1, 32'h00221820, 32'h5000, 32'd5, 32'd7);
        cycle();
        ex_ready = 1'b0;
        present(1'b1, 32'h3407FFFF, 32'h5004, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_ready: got %b expected 0", c, id_ready); end
            cycle();
            checks++; if (ex_valid !== 1'b1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_rd !== 5'd3 || ex_imm !== 32'h00001820 || ex_pc !== 32'h5000) begin errors++; $display("FAIL hold%0d_bundle: valid=%b a=%h b=%h rd=%0d imm=%h pc=%h expected 1/5/7/3/00001820/5000", c, ex_valid, ex_a, ex_b, ex_rd, ex_imm, ex_pc); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'h0000FFFF || ex_rd !== 5'd7 || ex_pc !== 32'h5004) begin errors++; $display("FAIL release_issue: valid=%b imm=%h rd=%0d pc=%h expected 1/0000FFFF/7/5004", ex_valid, ex_imm, ex_rd, ex_pc); end
    endtask

    task automatic test_mid_stall_reset();
        ex_ready = 1'b0;
        present(1'b1, 32'h00221820, 32'h6000, 32'd5, 32'd7);
        rst = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL msr_ready: got %b expected 0", id_ready); end
        cycle();
        checks++; if (ex_valid !== 1'b0 || ex_imm !== 32'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL msr_clear: valid=%b imm=%h rd=%0d expected 0/0/0", ex_valid, ex_imm, ex_rd); end
        rst = 1'b0;
        ex_ready = 1'b1;
        cycle();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h6000) begin errors++; $display("FAIL msr_replay: valid=%b pc=%h expected 1/6000", ex_valid, ex_pc); end
    endtask

    initial begin
        test_reset();
        test_decode_table();
        test_load_use();
        test_wb_conflict();
        test_flush();
        test_back_pressure();
        test_mid_stall_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

DLX instruction-decode stage with its ID/EX pipeline register. Splits the fetched instruction into register-file read addresses (driving `regs` Rs1/Rs2), captures the returned S1/S2 operands and the extended immediate, and presents one decoded instruction per cycle to execute over a valid/ready handshake. Detects load-use hazards, inserts bubbles, and honours branch flushes from EX.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  next-PC of the instruction
- id_ready  out  1  decode accepts if_instr this cycle
- Rs1, Rs2  out  5  combinational read addresses to `regs`
- S1, S2  in  32  combinational read data from `regs`
- wb_en, wb_rd, wb_data  in  1/5/32  writeback port, shared with `regs` WB/Rd/reg_s
- flush  in  1  taken branch/jump from EX; kill the instruction in ID
- ex_ready  in  1  execute accepts ex_* this cycle
- ex_valid  out  1  ex_* bundle holds a live instruction
- ex_op, ex_func  out  6/11  opcode; R-type function (0 for non-R)
- ex_a, ex_b, ex_imm, ex_pc  out  32  operand A, operand B, extended immediate, PC
- ex_rd  out  5  destination; 0 when no write
- ex_we, ex_is_load  out  1  writes a register; is a load

## Operation
- Fields: op=[31:26], rs1=[25:21]. R-type (op 0x00/0x01): rs2=[20:16], rd=[15:11], func=[10:0]. I-type: rd=[20:16], imm16=[15:0]. J-type (0x02 J, 0x03 JAL): off26=[25:0].
- Rs1=rs1 always. Rs2=[20:16] for R-type and stores (0x28/0x29/0x2B); 0 otherwise.
- ex_rd: R-type→[15:11]; JAL/JALR (0x13)→31; stores, BEQZ 0x04, BNEZ 0x05, J 0x02, JR 0x12→0 with ex_we=0; other I-type→[20:16]. ex_we=0 whenever the resulting rd==0.
- Immediate: ANDI/ORI/XORI (0x0C–0x0E) zero-extend imm16; LHI 0x0F yields imm16<<16; J/JAL sign-extend off26; all else sign-extend imm16.
- ex_is_load=1 for 0x20, 0x21, 0x23, 0x24, 0x25.
- Operand read: register 0 always reads 0, independent of S1/S2.
- Accept: transfer when if_valid && id_ready. ID/EX loads when !ex_valid || ex_ready.
- Load-use hazard: ex_valid && ex_is_load && ex_rd!=0 && ex_rd matches a used source (rs1, or rs2 when Rs2 is used) → id_ready=0; bubble inserted (ex_valid←0) when ID/EX advances.
- Priority: rst > flush > hazard > normal. flush: ex_valid←0 next edge, id_ready=1, and any if_instr presented that cycle is consumed and dropped.
- If !ex_valid-capable (ex_valid && !ex_ready): hold every ex_* stable; id_ready=0.

## Timing
- Rs1/Rs2→S1/S2→ex_a/ex_b is same-cycle combinational, registered at the edge: 1-cycle latency from accept to ex_valid.
- Reset: ex_valid=0, every ex_* =0, id_ready=0 while rst high, 1 from the first cycle after.
- Hazard costs exactly one bubble. The load advances, the dependent instruction is then re-evaluated with no hazard.
- Mid-stall reset: state cleared, stalled instruction lost; fetch replays.

## Configuration
- WB_BYPASS_EN defined: when wb_en && wb_rd!=0 && wb_rd equals a source, that operand is taken from wb_data instead of S1/S2. No extra stall.
- Undefined: the same match forces id_ready=0 for that cycle. The instruction is accepted next cycle after `regs` has committed the write.

## Structure
- Package dlx_pkg: opcode enum (all values above), field bit-position constants, and an id_ex_t struct for the ex_* bundle.
- One sub-module: decode_hazard, containing the load-use and WB-conflict comparators and producing stall.

## Test plan
- Reset held 2 cycles, then ADD r3,r1,r2 (0x00221820) with S1=5, S2=7 → next cycle ex_valid=1, ex_a=5, ex_b=7, ex_rd=3, ex_we=1.
- ADDI r7,r0,-1 (0x2007FFFF) → ex_imm=0xFFFFFFFF, ex_a=0 even with S1=0x1234; ORI r7,r0,0xFFFF → ex_imm=0x0000FFFF.
- LW r4,0(r1), then ADD r5,r4,r4 → id_ready=0 one cycle, one bubble (ex_valid=0), then ADD issues.
- wb_en=1, wb_rd=3, wb_data=222222 while decoding ADD r1,r3,r0: with the macro, ex_a=222222 and no stall; without it, a 1-cycle stall, then ex_a=S1.
- flush=1 with if_valid=1 → next cycle ex_valid=0 and that instruction never appears.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* unchanged and id_ready=0 throughout.
